display_scan_controller: RTL and testbench
==========================================

// Module: display_scan_controller
// PURPOSE
//   Owns a 4-digit BCD event counter and time-multiplexes one shared
//   BCD-to-7-segment decoder across four common-anode digits.
//   Counts rising edges of inc. Scans digits LSD->MSD, with a blanking gap
//   before each digit to prevent ghosting.
//   Optional leading-zero blanking.
//   Sits between the count/event source and the single 7-segment decoder.
// PARAMETERS
//   SCAN_DIV   4  clocks each digit is driven (SHOW length); legal range >=1
//   BLANK_CYC  2  clocks all digits are off before each digit (BLANK length); legal range >=1
// PORTS
//   count      in   1   clock, rising edge
//   reset      in   1   async active-low reset
//   inc        in   1   increment request; one increment per 0->1 transition
//   clr        in   1   sync clear of counter to 0000
//   lzb_en     in   1   1 = blank leading zeros
//   bcd        out  4   nibble to shared decoder (registered)
//   dig_sel_n  out  4   active-low digit enables, bit0 = least significant digit (registered)
//   blank      out  1   1 = no digit enabled this cycle (registered)
//   value      out  16  packed BCD count, [3:0] = least significant digit (registered)
//   carry      out  1   1-clock pulse on 9999->0000 wrap (registered)
// BEHAVIOUR
//   Reset (async, reset=0) sets every register, holding it while reset is low:
//     value=0, bcd=0, dig_sel_n=4'b1111, blank=1, carry=0, inc_q=0,
//     state=BLANK, idx=0, prescaler=0.
//   Edge detect: inc_q <= inc each clock; edge = inc & ~inc_q.
//     A level held high counts once.
//   Counter (per clock, clr has priority):
//     clr=1 -> value<=0, carry<=0; any coincident edge is discarded.
//     edge=1 -> BCD +1, 1-clock latency from the clock that samples the edge:
//       a digit at 9 goes to 0 and carries to the next digit;
//       9999 -> 0000 with carry<=1 for exactly that clock.
//     otherwise value holds and carry<=0.
//     No digit ever holds a value above 9.
//   Scan FSM, two states. The prescaler counts clocks within a state and
//     resets on every state change.
//     BLANK: dig_sel_n=1111, blank=1. After BLANK_CYC clocks -> SHOW.
//     SHOW:  dig_sel_n[idx]=0, others 1, blank=0. After SCAN_DIV clocks,
//       idx<=idx+1 mod 4 (3 wraps to 0) -> BLANK.
//     Frame length = 4*(BLANK_CYC+SCAN_DIV) clocks; reset enters BLANK with idx=0.
//   bcd <= value nibble[idx] every clock, in both states, so the decoder input
//     is settled before the digit enables. A value change is reflected on bcd
//     one clock later, including mid-SHOW.
//   Leading-zero blanking, evaluated each clock in SHOW from registered value:
//     if lzb_en=1, idx>0, and nibbles idx..3 are all 0 -> dig_sel_n=1111,
//     blank=1. FSM timing is unchanged.
//     Digit 0 is never suppressed, so 0000 shows a single "0".
//   Scan timing is independent of counter activity; clr and inc never
//     restart the scan.
//   Reset asserted mid-frame aborts the frame immediately, with all outputs
//     at their reset values.
//   Prescaler width = $clog2(max(SCAN_DIV,BLANK_CYC)+1).
// TESTING (SCAN_DIV=4, BLANK_CYC=2, frame=24 clocks)
//   reset low 3 clocks, release -> dig_sel_n=1111, blank=1 for 2 clocks,
//     then dig_sel_n=1110 for 4 clocks, then 1111 x2, then 1101;
//     idx 3 -> 0 wrap seen at clock 24.
//   5 inc pulses, 1 clock high / 1 clock low -> value=16'h0005.
//     inc held high 10 clocks -> value +1 only.
//   preload to 9999 via 9999 pulses, or force-load, then one more pulse
//     -> value=0000, carry high for exactly 1 clock.
//   value=0042, lzb_en=1 -> digits 2,3 show dig_sel_n=1111 in their SHOW
//     slots; digits 0,1 enable normally with bcd=2 and bcd=4.
//     With lzb_en=0, all four digits enable.
//   clr and an inc edge in the same clock -> value=0000, no increment;
//     value=0000 with lzb_en=1 -> only digit 0 lit, bcd=0.
//   reset pulsed low during a SHOW of idx=2
//     -> dig_sel_n=1111 and value=0 immediately (asynchronous);
//     after release the scan restarts with BLANK at idx=0.

Source files
------------

// File: rtl/display_scan_controller_if.sv
// Groups the counter/scan signals exchanged between the display scan
// controller and its surroundings.
//   inc, clr, lzb_en           : event source / configuration -> controller
//   bcd, dig_sel_n, blank      : controller -> shared 7-segment decoder / digit drivers
//   value, carry               : controller -> count consumer
interface display_scan_controller_if;
    logic        inc;
    logic        clr;
    logic        lzb_en;
    logic [3:0]  bcd;
    logic [3:0]  dig_sel_n;
    logic        blank;
    logic [15:0] value;
    logic        carry;

    modport master (
        output inc, clr, lzb_en,
        input  bcd, dig_sel_n, blank, value, carry
    );

    modport slave (
        input  inc, clr, lzb_en,
        output bcd, dig_sel_n, blank, value, carry
    );
endinterface

// File: rtl/display_scan_controller.sv
// 4-digit BCD event counter with a time-multiplexed scan of four
// common-anode digits through one shared BCD-to-7-segment decoder.
// Each digit is preceded by an all-off gap to avoid ghosting; optional
// leading-zero blanking.
// Ports:
//   count : clock, rising edge
//   reset : asynchronous active-low reset
//   bus   : slave side of display_scan_controller_if
//           inc (count request, one per 0->1), clr (sync clear), lzb_en,
//           bcd, dig_sel_n (bit0 = LSD), blank, value (packed BCD), carry
//
// state    | meaning
// ---------+-----------------------------------------------
// ST_BLANK | all digits off for BLANK_CYC clocks, bcd settles
// ST_SHOW  | digit idx enabled for SCAN_DIV clocks
module display_scan_controller #(
    parameter int SCAN_DIV  = 4,
    parameter int BLANK_CYC = 2
) (
    input  logic                        count,
    input  logic                        reset,
    display_scan_controller_if.slave    bus
);

    localparam int MAX_CYC = (SCAN_DIV > BLANK_CYC) ? SCAN_DIV : BLANK_CYC;
    localparam int PW      = $clog2(MAX_CYC + 1);
    localparam logic [PW-1:0] BLANK_LAST = PW'(BLANK_CYC - 1);
    localparam logic [PW-1:0] SHOW_LAST  = PW'(SCAN_DIV - 1);

    typedef enum logic {
        ST_BLANK = 1'b0,
        ST_SHOW  = 1'b1
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [1:0]    idx;
    logic [1:0]    idx_nxt;
    logic [PW-1:0] presc;
    logic [PW-1:0] presc_nxt;
    logic          inc_q;
    logic          inc_edge;
    logic [15:0]   value_inc;
    logic          ripple;
    logic          upper_zero;
    logic          suppress;

    assign inc_edge = bus.inc & ~inc_q;

    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        presc_nxt = presc + PW'(1);
        case (state)
            ST_BLANK: begin
                if (presc == BLANK_LAST) begin
                    state_nxt = ST_SHOW;
                    presc_nxt = '0;
                end
            end
            ST_SHOW: begin
                if (presc == SHOW_LAST) begin
                    state_nxt = ST_BLANK;
                    presc_nxt = '0;
                    idx_nxt   = idx + 2'd1;
                end
            end
            default: begin
                state_nxt = ST_BLANK;
                presc_nxt = '0;
            end
        endcase
    end

    // Ripple BCD increment; ripple left set after digit 3 means 9999 wrapped.
    always_comb begin
        value_inc = bus.value;
        ripple    = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (ripple) begin
                if (bus.value[4*i +: 4] >= 4'd9) begin
                    value_inc[4*i +: 4] = 4'd0;
                end else begin
                    value_inc[4*i +: 4] = bus.value[4*i +: 4] + 4'd1;
                    ripple = 1'b0;
                end
            end
        end
    end

    // Digit idx is a leading zero when it and every higher digit are 0.
    // Digit 0 is never blanked so a zero count still shows one "0".
    always_comb begin
        case (idx_nxt)
            2'd1:    upper_zero = (bus.value[15:4]  == 12'd0);
            2'd2:    upper_zero = (bus.value[15:8]  == 8'd0);
            2'd3:    upper_zero = (bus.value[15:12] == 4'd0);
            default: upper_zero = 1'b0;
        endcase
        suppress = bus.lzb_en & upper_zero;
    end

    always_ff @(posedge count or negedge reset) begin
        if (!reset) begin
            bus.value     <= 16'h0000;
            bus.carry     <= 1'b0;
            bus.bcd       <= 4'h0;
            bus.dig_sel_n <= 4'b1111;
            bus.blank     <= 1'b1;
            inc_q         <= 1'b0;
            state         <= ST_BLANK;
            idx           <= 2'd0;
            presc         <= '0;
        end else begin
            inc_q <= bus.inc;

            if (bus.clr) begin
                bus.value <= 16'h0000;
                bus.carry <= 1'b0;
            end else if (inc_edge) begin
                bus.value <= value_inc;
                bus.carry <= ripple;
            end else begin
                bus.carry <= 1'b0;
            end

            state <= state_nxt;
            idx   <= idx_nxt;
            presc <= presc_nxt;

            // Decoder input follows idx in both states so it is stable
            // before the digit enable arrives.
            bus.bcd <= bus.value[{idx, 2'b00} +: 4];

            // Enables are driven from the next state so they line up
            // with the state register.
            if (state_nxt == ST_SHOW && !suppress) begin
                bus.dig_sel_n <= ~(4'b0001 << idx_nxt);
                bus.blank     <= 1'b0;
            end else begin
                bus.dig_sel_n <= 4'b1111;
                bus.blank     <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_display_scan_controller.sv
// Directed bench for display_scan_controller (SCAN_DIV=4, BLANK_CYC=2).
module tb_display_scan_controller;

    logic count;
    logic reset;
    int   n_cmp;
    int   n_err;

    display_scan_controller_if dif ();

    display_scan_controller #(
        .SCAN_DIV  (4),
        .BLANK_CYC (2)
    ) dut (
        .count (count),
        .reset (reset),
        .bus   (dif.slave)
    );

    initial count = 1'b0;
    always #5 count = ~count;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge count);
    endtask

    task automatic pulse(input int n);
        for (int k = 0; k < n; k++) begin
            dif.inc = 1'b1;
            step();
            dif.inc = 1'b0;
            step();
        end
    endtask

    // Release reset at a falling edge and follow the scan for n clocks.
    // Sample e after release: q = e mod 24, slot = q / 6, first 2 of each slot blank.
    task automatic scan_after_release(input string tag, input int n);
        int q;
        logic [3:0] ed;
        logic       eb;
        reset = 1'b1;
        #1;
        for (int e = 0; e <= n; e++) begin
            if (e > 0) step();
            q = e % 24;
            if ((q % 6) < 2) begin
                ed = 4'b1111;
                eb = 1'b1;
            end else begin
                ed = ~(4'b0001 << (q / 6));
                eb = 1'b0;
            end
            check($sformatf("%s_dig_e%0d", tag, e), 32'(dif.dig_sel_n), 32'(ed));
            check($sformatf("%s_blank_e%0d", tag, e), 32'(dif.blank), 32'(eb));
        end
    endtask

    // Wait for the start of a digit-0 SHOW slot (bounded).
    task automatic align(input string tag);
        int  k;
        bit  found;
        k = 0;
        while (dif.dig_sel_n == 4'b1110 && k < 40) begin
            step();
            k++;
        end
        found = 1'b0;
        k = 0;
        while (!found && k < 40) begin
            if (dif.dig_sel_n == 4'b1110) found = 1'b1;
            else begin
                step();
                k++;
            end
        end
        check({tag, "_align"}, 32'(found), 32'd1);
    endtask

    // One frame from a digit-0 SHOW start: 4 SHOW clocks then 2 BLANK clocks per digit.
    task automatic check_frame(input string tag, input logic [15:0] ed, input logic [15:0] eb);
        int d;
        align(tag);
        for (int i = 0; i < 24; i++) begin
            d = i / 6;
            if ((i % 6) < 4) begin
                check($sformatf("%s_dig_i%0d", tag, i), 32'(dif.dig_sel_n), 32'(ed[4*d +: 4]));
                check($sformatf("%s_blank_i%0d", tag, i), 32'(dif.blank),
                      32'(ed[4*d +: 4] == 4'hF));
                check($sformatf("%s_bcd_i%0d", tag, i), 32'(dif.bcd), 32'(eb[4*d +: 4]));
            end else begin
                check($sformatf("%s_gap_i%0d", tag, i), 32'(dif.dig_sel_n), 32'hF);
            end
            step();
        end
    endtask

    initial begin
        n_cmp      = 0;
        n_err      = 0;
        reset      = 1'b0;
        dif.inc    = 1'b0;
        dif.clr    = 1'b0;
        dif.lzb_en = 1'b0;

        // reset state
        repeat (3) step();
        check("rst_value", 32'(dif.value), 32'h0);
        check("rst_bcd", 32'(dif.bcd), 32'h0);
        check("rst_dig", 32'(dif.dig_sel_n), 32'hF);
        check("rst_blank", 32'(dif.blank), 32'h1);
        check("rst_carry", 32'(dif.carry), 32'h0);

        // scan timing incl. idx 3->0 wrap at clock 24
        scan_after_release("scan", 27);

        // counting
        pulse(5);
        check("five_pulses", 32'(dif.value), 32'h0005);
        dif.inc = 1'b1;
        repeat (10) step();
        check("held_mid", 32'(dif.value), 32'h0006);
        dif.inc = 1'b0;
        step();
        check("held_after", 32'(dif.value), 32'h0006);

        pulse(93);
        check("to_0099", 32'(dif.value), 32'h0099);
        pulse(1);
        check("to_0100", 32'(dif.value), 32'h0100);
        check("no_carry_0100", 32'(dif.carry), 32'h0);
        pulse(9899);
        check("to_9999", 32'(dif.value), 32'h9999);
        check("no_carry_9999", 32'(dif.carry), 32'h0);
        dif.inc = 1'b1;
        step();
        check("wrap_value", 32'(dif.value), 32'h0000);
        check("wrap_carry", 32'(dif.carry), 32'h1);
        dif.inc = 1'b0;
        step();
        check("wrap_carry_drop", 32'(dif.carry), 32'h0);
        check("wrap_hold", 32'(dif.value), 32'h0000);

        // leading-zero blanking at 0042
        pulse(42);
        check("to_0042", 32'(dif.value), 32'h0042);
        dif.lzb_en = 1'b1;
        check_frame("lzb42", 16'hFF_DE, 16'h0042);
        dif.lzb_en = 1'b0;
        check_frame("nolzb42", 16'h7BDE, 16'h0042);

        // clr wins over a coincident edge
        dif.inc = 1'b1;
        dif.clr = 1'b1;
        step();
        check("clr_inc_value", 32'(dif.value), 32'h0000);
        dif.clr = 1'b0;
        step();
        check("clr_inc_no_late", 32'(dif.value), 32'h0000);
        dif.inc = 1'b0;
        dif.lzb_en = 1'b1;
        check_frame("lzb0", 16'hFFFE, 16'h0000);

        // async reset during SHOW of idx 2
        dif.lzb_en = 1'b0;
        pulse(3);
        check("pre_rst_value", 32'(dif.value), 32'h0003);
        align("mid");
        repeat (13) step();
        check("mid_dig2", 32'(dif.dig_sel_n), 32'hB);
        #2;
        reset = 1'b0;
        #1;
        check("async_dig", 32'(dif.dig_sel_n), 32'hF);
        check("async_value", 32'(dif.value), 32'h0);
        check("async_blank", 32'(dif.blank), 32'h1);
        step();
        check("held_rst_bcd", 32'(dif.bcd), 32'h0);
        scan_after_release("restart", 8);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
